seg_scan_ctrl: RTL

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_scan_ctrl_pkg.sv | 32 +++
 rtl/seg_scan_ctrl_seg_decoder.sv | 34 +++
 rtl/seg_scan_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/seg_scan_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_ctrl_pkg
// Description : Shared types and constants for the seven-segment scan
//               controller: scan FSM state encoding and abcdefg segment codes
//               (bit 6 = a, active-high).
// Revision    : 1.0 - initial release
// ============================================================================
package seg_scan_ctrl_pkg;

    // Scan sequencer states; two bits cover the three states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GAP   = 2'd2
    } scan_state_t;

    // Segment patterns for BCD digits, abcdefg order.
    localparam logic [6:0] SEG_0     = 7'h7E;
    localparam logic [6:0] SEG_1     = 7'h30;
    localparam logic [6:0] SEG_2     = 7'h6D;
    localparam logic [6:0] SEG_3     = 7'h79;
    localparam logic [6:0] SEG_4     = 7'h33;
    localparam logic [6:0] SEG_5     = 7'h5B;
    localparam logic [6:0] SEG_6     = 7'h5F;
    localparam logic [6:0] SEG_7     = 7'h70;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h7B;
    localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage : seg_scan_ctrl_pkg
`default_nettype wire

// File: rtl/seg_scan_ctrl_seg_decoder.sv
`default_nettype none
// ============================================================================
// Module      : seg_decoder
// Description : Combinational BCD nibble to seven-segment pattern decoder.
//               Non-BCD codes (10..15) decode to an unlit digit.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_decoder
    import seg_scan_ctrl_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] segments
);

    // Table lookup; anything outside 0..9 stays dark.
    always_comb begin
        segments = SEG_BLANK;
        case (nibble)
            4'd0:    segments = SEG_0;
            4'd1:    segments = SEG_1;
            4'd2:    segments = SEG_2;
            4'd3:    segments = SEG_3;
            4'd4:    segments = SEG_4;
            4'd5:    segments = SEG_5;
            4'd6:    segments = SEG_6;
            4'd7:    segments = SEG_7;
            4'd8:    segments = SEG_8;
            4'd9:    segments = SEG_9;
            default: segments = SEG_BLANK;
        endcase
    end

endmodule : seg_decoder
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_ctrl
// Description : Multiplexed seven-segment display scanner. Each digit is
//               driven for DWELL cycles followed by a one-cycle blank gap.
//               New values are staged in a one-entry pending register and
//               committed only at frame boundaries, so a frame never tears.
//               Optional leading-zero blanking.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_ctrl
    import seg_scan_ctrl_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int DWELL  = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  lzb,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [4*DIGITS-1:0]   load_data,
    output logic [6:0]            segments,
    output logic [DIGITS-1:0]     digit_sel,
    output logic                  frame_done
);

    localparam int                IDX_W    = $clog2(DIGITS);
    localparam int                CNT_W    = $clog2(DWELL);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DIGITS - 1);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(DWELL - 1);

    scan_state_t           state_q, state_d;
    logic [IDX_W-1:0]      index_q, index_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [4*DIGITS-1:0]   pending_q, pending_d;
    logic                  pending_valid_q, pending_valid_d;
    logic [4*DIGITS-1:0]   display_q, display_d;
    logic [6:0]            segments_q, segments_d;
    logic [DIGITS-1:0]     digit_sel_q, digit_sel_d;
    logic                  frame_done_q, frame_done_d;

    logic [3:0]            cur_nibble;
    logic [6:0]            cur_segments;
    logic [DIGITS-1:0]     upper_zero;
    logic                  blank_digit;

    // Sequencer, pending slot and frame-boundary commit.
    always_comb begin
        state_d         = state_q;
        index_d         = index_q;
        count_d         = count_q;
        pending_d       = pending_q;
        pending_valid_d = pending_valid_q;
        display_d       = display_q;

        // Accept only while the slot is empty; this can never coincide with
        // a commit because a commit requires the slot to be full.
        if (load_valid && !pending_valid_q) begin
            pending_d       = load_data;
            pending_valid_d = 1'b1;
        end

        if (!enable) begin
            state_d = ST_IDLE;
            index_d = '0;
            count_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_DRIVE;
                    index_d = '0;
                    count_d = '0;
                end
                ST_DRIVE: begin
                    if (count_q == LAST_CNT) begin
                        state_d = ST_GAP;
                        count_d = '0;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
                ST_GAP: begin
                    state_d = ST_DRIVE;
                    count_d = '0;
                    if (index_q == LAST_IDX) begin
                        index_d = '0;
                        // Frame boundary: the only place the display changes.
                        if (pending_valid_q) begin
                            display_d       = pending_q;
                            pending_valid_d = 1'b0;
                        end
                    end else begin
                        index_d = index_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    index_d = '0;
                    count_d = '0;
                end
            endcase
        end
    end

    // upper_zero[i] is set when nibble i and every nibble above it are zero.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_upper_zero
        assign upper_zero[gi] = (display_d[4*DIGITS-1:4*gi] == '0);
    end

    // Outputs are computed from next-cycle state so they register in step
    // with the state they describe.
    assign cur_nibble  = display_d[4*index_d +: 4];
    assign blank_digit = lzb && (index_d != '0) && upper_zero[index_d];

    seg_decoder u_seg_decoder (
        .nibble   (cur_nibble),
        .segments (cur_segments)
    );

    // Next registered output values: segments and digit_sel move together.
    always_comb begin
        segments_d   = SEG_BLANK;
        digit_sel_d  = '0;
        frame_done_d = 1'b0;
        if (state_d == ST_DRIVE) begin
            digit_sel_d = {{(DIGITS-1){1'b0}}, 1'b1} << index_d;
            segments_d  = blank_digit ? SEG_BLANK : cur_segments;
        end
        if ((state_d == ST_GAP) && (index_d == LAST_IDX)) begin
            frame_done_d = 1'b1;
        end
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            index_q         <= '0;
            count_q         <= '0;
            pending_q       <= '0;
            pending_valid_q <= 1'b0;
            display_q       <= '0;
            segments_q      <= SEG_BLANK;
            digit_sel_q     <= '0;
            frame_done_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            index_q         <= index_d;
            count_q         <= count_d;
            pending_q       <= pending_d;
            pending_valid_q <= pending_valid_d;
            display_q       <= display_d;
            segments_q      <= segments_d;
            digit_sel_q     <= digit_sel_d;
            frame_done_q    <= frame_done_d;
        end
    end

    assign load_ready = !pending_valid_q;
    assign segments   = segments_q;
    assign digit_sel  = digit_sel_q;
    assign frame_done = frame_done_q;

endmodule : seg_scan_ctrl
`default_nettype wire
